// File: rtl/obstacle_arb_pkg.sv
// obstacle_arb_pkg: shared width defaults and the read-owner tag type for the obstacle memory arbiter
package obstacle_arb_pkg;
  localparam int OBST_ADDR_W = 10;
  localparam int OBST_DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_GL} owner_t;
endpackage

// File: rtl/obstacle_arb_tagpipe.sv
// obstacle_arb_tagpipe: fixed-depth shift register of read owners, cleared synchronously by rst
module obstacle_arb_tagpipe
  import obstacle_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t tag_in,
  output owner_t tag_out
);
  owner_t pipe_d [DEPTH];
  owner_t pipe_q [DEPTH];
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++) pipe_q[i] <= rst ? OWN_NONE : pipe_d[i];
  assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/obstacle_mem_arbiter.sv
// obstacle_mem_arbiter: shares the obstacle memory port between renderer and game logic.
// Define OBSTACLE_ARB_STARVE_GUARD_EN to let starved game-logic requests override the renderer.
module obstacle_mem_arbiter
  import obstacle_arb_pkg::*;
#(
  parameter int ADDR_W       = OBST_ADDR_W,
  parameter int DATA_W       = OBST_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_gnt,
  output logic                vid_rvalid,
  output logic [DATA_W-1:0]   vid_rdata,
  input  logic                gl_req,
  input  logic                gl_we,
  input  logic [ADDR_W-1:0]   gl_addr,
  input  logic [DATA_W-1:0]   gl_wdata,
  input  logic [DATA_W/8-1:0] gl_be,
  output logic                gl_gnt,
  output logic                gl_rvalid,
  output logic [DATA_W-1:0]   gl_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_clken,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic                force_gl;
  logic                mem_chipselect_d, mem_chipselect_q;
  logic                mem_write_d, mem_write_q;
  logic [ADDR_W-1:0]   mem_address_d, mem_address_q;
  logic [DATA_W-1:0]   mem_writedata_d, mem_writedata_q;
  logic [DATA_W/8-1:0] mem_byteenable_d, mem_byteenable_q;
  owner_t              tag_in, tag_out;
`ifdef OBSTACLE_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_d, starve_cnt_q;
  assign force_gl = starve_cnt_q == CW'(STARVE_LIMIT);
  always_comb starve_cnt_d = (gl_gnt | ~gl_req) ? '0 : starve_cnt_q + 1'b1;
  always_ff @(posedge clk_clk) starve_cnt_q <= reset_reset ? '0 : starve_cnt_d;
`else
  assign force_gl = 1'b0;
`endif
  assign vid_gnt = ~reset_reset & vid_req & ~(gl_req & force_gl);
  assign gl_gnt  = ~reset_reset & gl_req & ~vid_gnt;
  always_comb begin
    mem_chipselect_d = vid_gnt | gl_gnt;
    mem_write_d      = gl_gnt & gl_we;
    mem_address_d    = vid_gnt ? vid_addr : gl_addr;
    mem_writedata_d  = mem_write_d ? gl_wdata : '0;
    mem_byteenable_d = mem_write_d ? gl_be : {(DATA_W/8){mem_chipselect_d}};
    tag_in           = vid_gnt ? OWN_VID : (gl_gnt & ~gl_we) ? OWN_GL : OWN_NONE;
  end
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
    end else begin
      mem_chipselect_q <= mem_chipselect_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
    end
  // tag depth covers the command register stage plus the memory latency
  obstacle_arb_tagpipe #(.DEPTH(1 + READ_LATENCY)) u_tagpipe (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );
  assign mem_clken      = ~reset_reset;
  assign mem_chipselect = mem_chipselect_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign vid_rvalid     = ~reset_reset & (tag_out == OWN_VID);
  assign gl_rvalid      = ~reset_reset & (tag_out == OWN_GL);
  assign vid_rdata      = mem_readdata;
  assign gl_rdata       = mem_readdata;
endmodule
